// File: rtl/pwm_capture.sv
// PWM receive-side measurement: recovers high time and period length between
// period strobes, flags multi-edge periods as glitches and drops over-long periods.
module pwm_capture #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cap_en,
    input  logic             pwm_period,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] meas_value,
    output logic [CNT_W-1:0] meas_range,
    output logic             meas_valid,
    output logic             meas_glitch,
    output logic             meas_ovf,
    output logic             busy
);

    localparam logic [CNT_W-1:0] MAX = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [1:0]       r_edge_cnt;
    logic             r_prev_in;
    logic [CNT_W-1:0] r_meas_value;
    logic [CNT_W-1:0] r_meas_range;
    logic             r_meas_valid;
    logic             r_meas_glitch;
    logic             r_meas_ovf;
    logic             r_busy;

    logic             w_rise;
    logic [CNT_W-1:0] w_hi_inc;
    logic [CNT_W-1:0] w_one;

    assign w_rise   = pwm_in & ~r_prev_in;
    assign w_hi_inc = {{(CNT_W-1){1'b0}}, pwm_in};
    assign w_one    = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_per_cnt     <= '0;
            r_hi_cnt      <= '0;
            r_edge_cnt    <= 2'd0;
            r_prev_in     <= 1'b0;
            r_meas_value  <= '0;
            r_meas_range  <= '0;
            r_meas_valid  <= 1'b0;
            r_meas_glitch <= 1'b0;
            r_meas_ovf    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            r_meas_ovf   <= 1'b0;
            if (!cap_en) begin
                // Disable wins over a coincident strobe: the open period is discarded.
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_per_cnt  <= '0;
                r_hi_cnt   <= '0;
                r_edge_cnt <= 2'd0;
                r_prev_in  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= ARM;
                        r_busy  <= 1'b1;
                    end
                    ARM: begin
                        if (pwm_period) begin
                            r_state    <= MEASURE;
                            r_per_cnt  <= w_one;
                            r_hi_cnt   <= w_hi_inc;
                            r_edge_cnt <= {1'b0, pwm_in};
                            r_prev_in  <= pwm_in;
                        end
                    end
                    MEASURE: begin
                        if (pwm_period) begin
                            // Strobe closes the old period and is cycle 0 of the next one.
                            r_meas_range  <= r_per_cnt;
                            r_meas_value  <= r_hi_cnt;
                            r_meas_glitch <= r_edge_cnt[1];
                            r_meas_valid  <= 1'b1;
                            r_per_cnt     <= w_one;
                            r_hi_cnt      <= w_hi_inc;
                            r_edge_cnt    <= {1'b0, pwm_in};
                            r_prev_in     <= pwm_in;
                        end else if (r_per_cnt == MAX) begin
                            r_meas_ovf <= 1'b1;
                            r_state    <= ARM;
                            r_per_cnt  <= '0;
                            r_hi_cnt   <= '0;
                            r_edge_cnt <= 2'd0;
                            r_prev_in  <= 1'b0;
                        end else begin
                            r_per_cnt <= r_per_cnt + w_one;
                            r_hi_cnt  <= r_hi_cnt + w_hi_inc;
                            r_prev_in <= pwm_in;
                            if (w_rise && (r_edge_cnt != 2'd3)) begin
                                r_edge_cnt <= r_edge_cnt + 2'd1;
                            end
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign meas_value  = r_meas_value;
    assign meas_range  = r_meas_range;
    assign meas_valid  = r_meas_valid;
    assign meas_glitch = r_meas_glitch;
    assign meas_ovf    = r_meas_ovf;
    assign busy        = r_busy;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: each driven period pushes its expected
// result derived from the waveform; a negedge monitor pops on meas_valid.
module tb_pwm_capture;

    logic       clk;
    logic       reset;
    logic       cap_en;
    logic       pwm_period;
    logic       pwm_in;
    logic [7:0] meas_value;
    logic [7:0] meas_range;
    logic       meas_valid;
    logic       meas_glitch;
    logic       meas_ovf;
    logic       busy;

    typedef struct {
        logic [7:0] v;
        logic [7:0] r;
        logic       g;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] last_val = 8'd0;
    logic [7:0] last_rng = 8'd0;

    pwm_capture #(.CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .cap_en     (cap_en),
        .pwm_period (pwm_period),
        .pwm_in     (pwm_in),
        .meas_value (meas_value),
        .meas_range (meas_range),
        .meas_valid (meas_valid),
        .meas_glitch(meas_glitch),
        .meas_ovf   (meas_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result monitor: every meas_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && meas_valid === 1'b1) begin
            exp_t e;
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got value=%0d range=%0d, required no result",
                         meas_value, meas_range);
            end else begin
                e = exp_q.pop_front();
                last_val = e.v;
                last_rng = e.r;
                if (meas_value !== e.v || meas_range !== e.r || meas_glitch !== e.g) begin
                    n_err++;
                    $display("FAIL result: got value=%0d range=%0d glitch=%0b, required value=%0d range=%0d glitch=%0b",
                             meas_value, meas_range, meas_glitch, e.v, e.r, e.g);
                end else begin
                    $display("result value=%0d range=%0d glitch=%0b", meas_value, meas_range, meas_glitch);
                end
            end
            if (meas_ovf !== 1'b0) begin
                n_err++;
                $display("FAIL valid_with_ovf: got ovf=%0b, required 0", meas_ovf);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One PWM period: pat[i] is pwm_in on cycle i; strobe on cycle 0.
    task automatic run_period(input int len, input logic [255:0] pat, input bit expect_res);
        exp_t e;
        int   hi;
        int   ed;
        hi = 0;
        ed = 0;
        for (int i = 0; i < len; i++) begin
            if (pat[i]) begin
                hi++;
                if (i == 0) ed++;
                else if (!pat[i-1]) ed++;
            end
        end
        if (expect_res) begin
            e.v = 8'(hi);
            e.r = 8'(len);
            e.g = (ed >= 2);
            exp_q.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            pwm_period = (i == 0);
            pwm_in     = pat[i];
            tick();
        end
        pwm_period = 1'b0;
    endtask

    task automatic stop_capture();
        cap_en     = 1'b0;
        pwm_period = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        cap_en     = 1'b1;
        pwm_period = 1'b1;
        pwm_in     = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (meas_value !== 8'd0 || meas_range !== 8'd0 || meas_valid !== 1'b0 ||
            meas_glitch !== 1'b0 || meas_ovf !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got value=%0d range=%0d valid=%0b glitch=%0b ovf=%0b busy=%0b, required all 0",
                     meas_value, meas_range, meas_valid, meas_glitch, meas_ovf, busy);
        end
        cap_en     = 1'b0;
        pwm_period = 1'b0;
        pwm_in     = 1'b0;
        reset      = 1'b1;
        tick();
    endtask

    task automatic test_duty();
        logic [255:0] p;
        p = '0;
        p[2:0] = 3'b111;
        cap_en = 1'b1;
        tick();
        run_period(10, p, 1);
        run_period(10, p, 1);
        // Result must be visible exactly one clock after the closing strobe.
        exp_q.push_back('{v: 8'd3, r: 8'd10, g: 1'b0});
        pwm_period = 1'b1;
        pwm_in     = p[0];
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (meas_valid !== 1'b1 || meas_value !== 8'd3 || meas_range !== 8'd10) begin
            n_err++;
            $display("FAIL duty_latency: got valid=%0b value=%0d range=%0d, required valid=1 value=3 range=10",
                     meas_valid, meas_value, meas_range);
        end
        pwm_period = 1'b0;
        pwm_in     = p[1];
        for (int i = 2; i < 10; i++) begin
            tick();
            pwm_in = p[i];
        end
        tick();
        run_period(1, p, 0);
        stop_capture();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL duty_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_patterns();
        logic [255:0] p12;
        p12 = '0;
        p12[1:0] = 2'b11;
        p12[6:5] = 2'b11;
        cap_en = 1'b1;
        tick();
        run_period(8, '0, 1);
        run_period(8, '0, 1);
        run_period(8, '1, 1);
        run_period(8, '1, 1);
        run_period(12, p12, 1);
        run_period(12, p12, 1);
        run_period(1, '0, 0);
        stop_capture();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL patterns_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [7:0] hold_rng;
        hold_rng = last_rng;
        cap_en = 1'b1;
        tick();
        pwm_period = 1'b1;
        pwm_in     = 1'b0;
        tick();
        pwm_period = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (meas_ovf !== (k == 255) || busy !== 1'b1) begin
                n_err++;
                $display("FAIL ovf_cycle%0d: got ovf=%0b busy=%0b, required ovf=%0b busy=1",
                         k, meas_ovf, busy, (k == 255));
            end
        end
        n_vec++;
        if (meas_range !== hold_rng) begin
            n_err++;
            $display("FAIL ovf_hold: got range=%0d, required %0d", meas_range, hold_rng);
        end
        run_period(20, '0, 1);
        run_period(1, '0, 0);
        stop_capture();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL ovf_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_cap_drop();
        logic [255:0] p;
        logic [255:0] q;
        p = '0;
        p[2:0] = 3'b111;
        q = '0;
        q[5:0] = 6'h3f;
        cap_en = 1'b1;
        tick();
        run_period(10, p, 1);
        run_period(10, p, 0);
        pwm_period = 1'b1;
        cap_en     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (meas_valid !== 1'b0 || busy !== 1'b0 || meas_value !== 8'd3 || meas_range !== 8'd10) begin
            n_err++;
            $display("FAIL cap_drop: got valid=%0b busy=%0b value=%0d range=%0d, required 0/0/3/10",
                     meas_valid, busy, meas_value, meas_range);
        end
        for (int k = 0; k < 4; k++) begin
            pwm_period = k[0];
            @(posedge clk);
            @(negedge clk);
        end
        cap_en     = 1'b1;
        pwm_period = 1'b0;
        tick();
        run_period(10, q, 1);
        run_period(10, q, 1);
        run_period(1, '0, 0);
        stop_capture();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL cap_drop_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] b;
        cap_en = 1'b1;
        tick();
        for (int k = 0; k < 12; k++) begin
            b = '0;
            b[0] = 1'($urandom_range(0, 1));
            run_period(1, b, 1);
        end
        run_period(1, '0, 0);
        stop_capture();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] p;
        p = '0;
        p[2:0] = 3'b111;
        cap_en = 1'b1;
        tick();
        run_period(10, p, 1);
        run_period(4, p, 0);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (meas_value !== 8'd0 || meas_range !== 8'd0 || meas_valid !== 1'b0 ||
            meas_glitch !== 1'b0 || meas_ovf !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: got value=%0d range=%0d valid=%0b glitch=%0b ovf=%0b busy=%0b, required all 0",
                     meas_value, meas_range, meas_valid, meas_glitch, meas_ovf, busy);
        end
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || meas_range !== 8'd0) begin
            n_err++;
            $display("FAIL rearm_wait: got busy=%0b range=%0d, required busy=1 range=0", busy, meas_range);
        end
        tick();
        run_period(7, p, 1);
        run_period(1, '0, 0);
        stop_capture();
        n_vec++;
        if (exp_q.size() != 0 || meas_range !== 8'd7) begin
            n_err++;
            $display("FAIL reset_mid_drain: got pending=%0d range=%0d, required 0 and 7",
                     exp_q.size(), meas_range);
        end
    endtask

    initial begin
        reset      = 1'b0;
        cap_en     = 1'b0;
        pwm_period = 1'b0;
        pwm_in     = 1'b0;
        test_reset();
        test_duty();
        test_patterns();
        test_overflow();
        test_cap_drop();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
